// File: rtl/io_dbg_master.sv
// Byte-stream debug initiator: decodes 'W'/'R' commands into single MCS-style IO
// bus transactions and streams back the completion status or the read data.
module io_dbg_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned RX_GAP  = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        io_addr_strobe,
  output logic        io_read_strobe,
  output logic        io_write_strobe,
  output logic [3:0]  io_byte_enable,
  output logic [31:0] io_address,
  output logic [31:0] io_write_data,
  input  logic [31:0] io_read_data,
  input  logic        io_ready,
  output logic        busy,
  output logic        drop
);

  localparam int unsigned GAP_W = (RX_GAP < 2) ? 1 : $clog2(RX_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RX_GAP - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT);

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_TMO = 8'h54;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [7:0]       wait_cnt, wait_nxt;
  logic             is_write, is_write_nxt;
  logic             single, single_nxt;
  logic [31:0]      rdata, rdata_nxt;
  logic [31:0]      addr_nxt, wdata_nxt;
  logic [7:0]       tx_byte_nxt;
  logic             tx_valid_nxt;
  logic             issue;
  logic             drop_nxt;

  // Next-state and next-register values; every output register is loaded from here.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    gap_nxt      = gap_cnt;
    wait_nxt     = wait_cnt;
    is_write_nxt = is_write;
    single_nxt   = single;
    rdata_nxt    = rdata;
    addr_nxt     = io_address;
    wdata_nxt    = io_write_data;
    tx_byte_nxt  = tx_byte;
    tx_valid_nxt = tx_valid;
    issue        = 1'b0;
    drop_nxt     = rx_valid && (state == S_ISSUE || state == S_WAIT || state == S_SEND);

    case (state)
      S_IDLE: begin
        idx_nxt = 2'd0;
        gap_nxt = '0;
        if (rx_valid && (rx_byte == CMD_WR || rx_byte == CMD_RD)) begin
          is_write_nxt = (rx_byte == CMD_WR);
          state_nxt    = S_ADDR;
        end
      end

      S_ADDR, S_DATA: begin
        if (rx_valid) begin
          gap_nxt = '0;
          idx_nxt = idx + 2'd1;
          if (state == S_ADDR) addr_nxt  = {io_address[23:0], rx_byte};
          else                 wdata_nxt = {io_write_data[23:0], rx_byte};
          if (idx == 2'd3) begin
            idx_nxt = 2'd0;
            if (state == S_ADDR && is_write) begin
              state_nxt = S_DATA;
            end else begin
              state_nxt = S_ISSUE;
              issue     = 1'b1;
            end
          end
        end else if (gap_cnt == GAP_LAST) begin
          // Host went quiet mid-command: abandon the partial command.
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end

      S_ISSUE: begin
        state_nxt = S_WAIT;
        wait_nxt  = 8'd1;
      end

      S_WAIT: begin
        if (io_ready) begin
          state_nxt    = S_SEND;
          idx_nxt      = 2'd0;
          tx_valid_nxt = 1'b1;
          single_nxt   = is_write;
          if (is_write) begin
            tx_byte_nxt = RSP_OK;
          end else begin
            tx_byte_nxt = io_read_data[31:24];
            rdata_nxt   = {io_read_data[23:0], 8'h00};
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt    = S_SEND;
          idx_nxt      = 2'd0;
          tx_valid_nxt = 1'b1;
          single_nxt   = 1'b1;
          tx_byte_nxt  = RSP_TMO;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end

      S_SEND: begin
        if (tx_ready) begin
          if (single || idx == 2'd3) begin
            tx_valid_nxt = 1'b0;
            idx_nxt      = 2'd0;
            state_nxt    = S_IDLE;
          end else begin
            tx_byte_nxt = rdata[31:24];
            rdata_nxt   = {rdata[23:0], 8'h00};
            idx_nxt     = idx + 2'd1;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      idx             <= 2'd0;
      gap_cnt         <= '0;
      wait_cnt        <= 8'd0;
      is_write        <= 1'b0;
      single          <= 1'b0;
      rdata           <= 32'd0;
      io_address      <= 32'd0;
      io_write_data   <= 32'd0;
      tx_byte         <= 8'd0;
      tx_valid        <= 1'b0;
      io_addr_strobe  <= 1'b0;
      io_read_strobe  <= 1'b0;
      io_write_strobe <= 1'b0;
      io_byte_enable  <= 4'h0;
      busy            <= 1'b0;
      drop            <= 1'b0;
    end else begin
      state           <= state_nxt;
      idx             <= idx_nxt;
      gap_cnt         <= gap_nxt;
      wait_cnt        <= wait_nxt;
      is_write        <= is_write_nxt;
      single          <= single_nxt;
      rdata           <= rdata_nxt;
      io_address      <= addr_nxt;
      io_write_data   <= wdata_nxt;
      tx_byte         <= tx_byte_nxt;
      tx_valid        <= tx_valid_nxt;
      io_addr_strobe  <= issue;
      io_read_strobe  <= issue && !is_write;
      io_write_strobe <= issue && is_write;
      io_byte_enable  <= issue ? 4'hF : 4'h0;
      busy            <= (state_nxt != S_IDLE);
      drop            <= drop_nxt;
    end
  end

endmodule

// File: doc/io_dbg_master.md
# io_dbg_master

UART-driven debug initiator for the MCS-style IO bus. It decodes a byte command stream into single 32-bit read/write transactions on an IO bus that has the same signal set and handshake as the MicroBlaze MCS IO port. It returns the completion status and read data as a byte stream. It sits in place of, or muxed ahead of, the CPU at the input of `mcs_bridge`, so the board's MMIO cores can be poked from a host PC with no firmware running.

## Interface
- `TIMEOUT`, default 255: maximum cycles to wait for `io_ready` after a strobe; 8-bit counter.
- `RX_GAP`, default 100_000: maximum idle cycles between bytes of one command before the partial command is discarded.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `rx_byte` in 8: received command byte.
- `rx_valid` in 1: one-cycle strobe, `rx_byte` valid.
- `tx_byte` out 8: response byte.
- `tx_valid` out 1: response byte valid; held until accepted.
- `tx_ready` in 1: sink accepts `tx_byte` when `tx_valid && tx_ready`.
- `io_addr_strobe` out 1: one-cycle transaction strobe.
- `io_read_strobe` out 1: one-cycle read strobe.
- `io_write_strobe` out 1: one-cycle write strobe.
- `io_byte_enable` out 4: always 4'hF while strobing, else 0.
- `io_address` out 32: transaction address, held stable from strobe until completion.
- `io_write_data` out 32: write data, held stable from strobe until completion.
- `io_read_data` in 32: read data, valid when `io_ready`=1.
- `io_ready` in 1: transaction completion from the responder.
- `busy` out 1: high in every state except IDLE.
- `drop` out 1: one-cycle pulse when a received byte is discarded.

## Operation
- Command formats, multi-byte fields sent MSB first:
  - Write: 0x57 ('W'), A3 A2 A1 A0, D3 D2 D1 D0.
  - Read: 0x52 ('R'), A3 A2 A1 A0.
- Responses:
  - Successful write returns 0x4B ('K').
  - Successful read returns D3 D2 D1 D0 of `io_read_data` as captured on `io_ready`.
  - Timeout on either command returns the single byte 0x54 ('T').
- In IDLE, any byte other than 0x57 or 0x52 is ignored silently; no `drop` pulse.
- FSM states: IDLE, ADDR (4 bytes), DATA (4 bytes, write only), ISSUE, WAIT, SEND.
  - IDLE → ADDR on a valid command byte; the read/write flag is latched.
  - ADDR → DATA (write) or ISSUE (read) after the 4th address byte.
  - DATA → ISSUE after the 4th data byte.
  - ISSUE lasts one cycle: the address strobe, the matching read or write strobe, and `io_byte_enable`=F are all asserted; then → WAIT.
  - WAIT exits on `io_ready`, capturing `io_read_data`, or when the wait counter reaches `TIMEOUT` → SEND.
  - SEND presents the response bytes in sequence; → IDLE after the last byte is accepted.
- A 2-bit byte index is used in ADDR/DATA/SEND and cleared on each state entry.
- Inter-byte gap counter:
  - Cleared on each accepted byte; counts only in ADDR/DATA.
  - Reaching `RX_GAP` → IDLE with the partial command discarded; no response, no bus activity.
- `rx_valid` in ISSUE, WAIT or SEND: the byte is discarded and `drop` pulses in the following cycle. There is no buffering.
- `io_ready` outside WAIT is ignored; this includes the ISSUE cycle.
- A new command is accepted in the cycle after the final SEND handshake.

## Timing
- All outputs are registered.
- Reset values: all strobes 0, `io_byte_enable`=0, `io_address`=0, `io_write_data`=0, `tx_byte`=0, `tx_valid`=0, `busy`=0, `drop`=0, state=IDLE.
- Last command byte on `rx_valid` at cycle t → strobes high in cycle t+1 only.
- `io_ready` sampled high at cycle t+1+k (k≥1) → `tx_valid` high from cycle t+2+k.
- Timeout: with no `io_ready`, `tx_valid` carrying 'T' rises at cycle t+2+`TIMEOUT`.
- A late `io_ready` after the timeout is ignored.
- `tx_byte` is stable while `tx_valid`=1 and `tx_ready`=0.
- Next byte appears in the cycle after a handshake, so back-to-back `tx_ready` gives one byte per cycle.
- `reset` mid-transaction returns to IDLE immediately and drops outstanding strobes and response bytes. A responder that is mid-transaction must tolerate this.

## Test plan
- Write: send 57 C0 00 00 10 12 34 56 78; responder raises `io_ready` 2 cycles after the strobe.
  - Expect one-cycle `io_addr_strobe`/`io_write_strobe`, `io_address`=C000_0010, `io_write_data`=1234_5678, `io_byte_enable`=F.
  - Expect `tx_byte`=4B.
- Read: send 52 C0 00 00 04; responder returns `io_read_data`=DEAD_BEEF.
  - Expect `io_read_strobe` pulse, `io_address`=C000_0004.
  - Expect tx bytes DE AD BE EF in order.
  - Stall `tx_ready` low 5 cycles mid-stream; bytes must not change.
- Timeout: `TIMEOUT`=8, send a read, never raise `io_ready`.
  - Expect a single 'T' (54) at strobe+9.
  - A later `io_ready` pulse causes no extra output.
- Gap/junk: send 41, then 57 C0 and stop.
  - After `RX_GAP` cycles `busy`=0 with no strobe.
  - A following valid read completes normally.
- Overrun: send a byte while in WAIT.
  - Expect a `drop` pulse and an unchanged transaction result.
- Reset: assert `reset` in WAIT.
  - Expect all outputs at their reset values at once and IDLE afterwards.
  - A subsequent write succeeds.
